// File: rtl/qm_pkg.sv
// qm_pkg: shared constants for the q3kmips decode stage.
//   IMM_* : immediate extension modes presented on ci_ImmMode
//   *_LSB : bit positions of the MIPS instruction fields inside the IR
package qm_pkg;

  localparam logic [1:0] IMM_SIGN  = 2'd0;
  localparam logic [1:0] IMM_ZERO  = 2'd1;
  localparam logic [1:0] IMM_UPPER = 2'd2;

  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  function automatic logic [5:0] ir_opcode(input logic [31:0] ir);
    return ir[OP_LSB +: 6];
  endfunction

  function automatic logic [5:0] ir_funct(input logic [31:0] ir);
    return ir[FN_LSB +: 6];
  endfunction

endpackage

// File: rtl/qm_decode_stage_if.sv
// qm_decode_stage_if: fetch->decode handshake plus the ID/EX output bundle.
//   di_Valid/di_IR/do_Ready : instruction hand-off from fetch
//   do_* / co_Ctrl          : registered ID/EX entry toward execute
//   master : fetch / execute side      slave : decode stage
interface qm_decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 10
);
  logic              di_Valid;
  logic [31:0]       di_IR;
  logic              do_Ready;
  logic              do_Valid;
  logic [XLEN-1:0]   do_RSVal;
  logic [XLEN-1:0]   do_RTVal;
  logic [XLEN-1:0]   do_Imm;
  logic [RA_W-1:0]   do_RS;
  logic [RA_W-1:0]   do_RT;
  logic [RA_W-1:0]   do_RD;
  logic [CTRL_W-1:0] co_Ctrl;

  modport master (
    output di_Valid, di_IR,
    input  do_Ready, do_Valid, do_RSVal, do_RTVal, do_Imm,
           do_RS, do_RT, do_RD, co_Ctrl
  );

  modport slave (
    input  di_Valid, di_IR,
    output do_Ready, do_Valid, do_RSVal, do_RTVal, do_Imm,
           do_RS, do_RT, do_RD, co_Ctrl
  );
endinterface

// File: rtl/qm_regfile.sv
// qm_regfile: NREGS x XLEN register file, 2 async read ports, 1 sync write.
//   sys_clk/sys_rst_n : clock, async active-low reset (clears all entries)
//   i_RA1/i_RA2       : read addresses -> o_RD1/o_RD2
//   i_WE/i_WA/i_WD    : write port; also bypassed to a matching read
// Register 0 is hard-wired to zero.
module qm_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [RA_W-1:0] i_RA1,
  input  logic [RA_W-1:0] i_RA2,
  output logic [XLEN-1:0] o_RD1,
  output logic [XLEN-1:0] o_RD2,
  input  logic            i_WE,
  input  logic [RA_W-1:0] i_WA,
  input  logic [XLEN-1:0] i_WD
);

  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_WE && (i_WA != '0)) begin
      r_mem[i_WA] <= i_WD;
    end
  end

  // Write-through: a same-cycle write to the address being read wins.
  always_comb begin
    o_RD1 = r_mem[i_RA1];
    if (i_RA1 == '0)                   o_RD1 = '0;
    else if (i_WE && (i_WA == i_RA1))  o_RD1 = i_WD;
  end

  always_comb begin
    o_RD2 = r_mem[i_RA2];
    if (i_RA2 == '0)                   o_RD2 = '0;
    else if (i_WE && (i_WA == i_RA2))  o_RD2 = i_WD;
  end

endmodule

// File: rtl/qm_decode_stage.sv
// qm_decode_stage: registered MIPS decode stage (IF/ID -> ID/EX).
//   sys_clk, sys_rst_n        : clock, async active-low reset
//   bus (slave)               : fetch handshake in, ID/EX entry out
//   di_WA/di_WE/di_WD         : writeback port into the register file
//   o_Opcode/o_Function       : raw IR fields to the external control unit
//   ci_Ctrl/ci_ImmMode        : control bundle and immediate mode back from it
//   i_EX_MemRead/i_EX_RT      : load in EX, for load-use detection
//   i_Stall/i_Flush           : downstream hold / squash of decode
module qm_decode_stage
  import qm_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int CTRL_W = 10,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  qm_decode_stage_if.slave  bus,
  input  logic [RA_W-1:0]   di_WA,
  input  logic              di_WE,
  input  logic [XLEN-1:0]   di_WD,
  output logic [5:0]        o_Opcode,
  output logic [5:0]        o_Function,
  input  logic [CTRL_W-1:0] ci_Ctrl,
  input  logic [1:0]        ci_ImmMode,
  input  logic              i_EX_MemRead,
  input  logic [RA_W-1:0]   i_EX_RT,
  input  logic              i_Stall,
  input  logic              i_Flush
);

  logic [RA_W-1:0]  w_rs, w_rt, w_rd;
  logic [15:0]      w_imm16;
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_rsval, w_rtval;
  logic             w_hazard;
  logic             w_load;

  logic              r_vld;
  logic [XLEN-1:0]   r_rsval, r_rtval, r_imm;
  logic [RA_W-1:0]   r_rs, r_rt, r_rd;
  logic [CTRL_W-1:0] r_ctrl;

  // Field addresses are simply truncated to the regfile address width.
  assign w_rs    = bus.di_IR[RS_LSB +: RA_W];
  assign w_rt    = bus.di_IR[RT_LSB +: RA_W];
  assign w_rd    = bus.di_IR[RD_LSB +: RA_W];
  assign w_imm16 = bus.di_IR[IMM_LSB +: IMM_W];

  assign o_Opcode   = ir_opcode(bus.di_IR);
  assign o_Function = ir_funct(bus.di_IR);

  qm_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_RA1     (w_rs),
    .i_RA2     (w_rt),
    .o_RD1     (w_rsval),
    .o_RD2     (w_rtval),
    .i_WE      (di_WE),
    .i_WA      (di_WA),
    .i_WD      (di_WD)
  );

  // Mode 3 is unassigned and falls back to sign extension.
  always_comb begin
    w_imm = {{(XLEN-IMM_W){w_imm16[15]}}, w_imm16};
    case (ci_ImmMode)
      IMM_ZERO:  w_imm = {{(XLEN-IMM_W){1'b0}}, w_imm16};
      IMM_UPPER: w_imm = XLEN'({w_imm16, 16'h0000});
      default:   ;
    endcase
  end

  // A load in EX whose destination we read must be waited out one cycle.
  assign w_hazard = bus.di_Valid & i_EX_MemRead & (i_EX_RT != '0) &
                    ((i_EX_RT == w_rs) | (i_EX_RT == w_rt));

  // Flush always frees fetch; otherwise stall or a hazard holds the IR.
  assign bus.do_Ready = i_Flush | (~i_Stall & ~w_hazard);

  // Fields load on both the normal and the hazard path so a bubble still
  // carries deterministic data; only the valid bit distinguishes them.
  assign w_load = ~i_Flush & ~i_Stall;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vld   <= 1'b0;
      r_rsval <= '0;
      r_rtval <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_ctrl  <= '0;
    end else if (i_Flush) begin
      r_vld   <= 1'b0;
    end else if (w_load) begin
      r_vld   <= bus.di_Valid & ~w_hazard;
      r_rsval <= w_rsval;
      r_rtval <= w_rtval;
      r_imm   <= w_imm;
      r_rs    <= w_rs;
      r_rt    <= w_rt;
      r_rd    <= w_rd;
      r_ctrl  <= ci_Ctrl;
    end
  end

  assign bus.do_Valid = r_vld;
  assign bus.do_RSVal = r_rsval;
  assign bus.do_RTVal = r_rtval;
  assign bus.do_Imm   = r_imm;
  assign bus.do_RS    = r_rs;
  assign bus.do_RT    = r_rt;
  assign bus.do_RD    = r_rd;
  assign bus.co_Ctrl  = r_ctrl;

endmodule

// File: tb/tb_qm_decode_stage.sv
module tb_qm_decode_stage;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [4:0]  di_WA;
  logic        di_WE;
  logic [31:0] di_WD;
  logic [5:0]  o_Opcode, o_Function;
  logic [9:0]  ci_Ctrl;
  logic [1:0]  ci_ImmMode;
  logic        i_EX_MemRead;
  logic [4:0]  i_EX_RT;
  logic        i_Stall, i_Flush;

  qm_decode_stage_if #(.XLEN(32), .RA_W(5), .CTRL_W(10)) bus ();

  qm_decode_stage #(.XLEN(32), .NREGS(32), .CTRL_W(10)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .bus          (bus),
    .di_WA        (di_WA),
    .di_WE        (di_WE),
    .di_WD        (di_WD),
    .o_Opcode     (o_Opcode),
    .o_Function   (o_Function),
    .ci_Ctrl      (ci_Ctrl),
    .ci_ImmMode   (ci_ImmMode),
    .i_EX_MemRead (i_EX_MemRead),
    .i_EX_RT      (i_EX_RT),
    .i_Stall      (i_Stall),
    .i_Flush      (i_Flush)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    bit v; bit [31:0] ir; bit we; bit [4:0] wa; bit [31:0] wd; bit [1:0] mode;
    bit mr; bit [4:0] exrt; bit st; bit fl; bit [9:0] ctrl;
  } stim_t;

  typedef struct packed {
    bit valid; bit [31:0] rsval; bit [31:0] rtval; bit [31:0] imm;
    bit [4:0] rs; bit [4:0] rt; bit [4:0] rd; bit [9:0] ctrl;
  } idex_t;

  typedef struct packed {
    bit ready; bit [5:0] op; bit [5:0] fn; idex_t st;
  } rec_t;

  rec_t        sb[$];
  idex_t       m_st;
  bit [31:0]   m_rf [32];
  int          n_err = 0;
  int          n_chk = 0;
  rec_t        mon_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference register read: r0 is zero, a same-cycle write is visible.
  function automatic bit [31:0] rf_read(input bit [4:0] a, input stim_t s);
    if (a == 5'd0) return 32'd0;
    if (s.we && s.wa == a) return s.wd;
    return m_rf[a];
  endfunction

  function automatic bit [31:0] ext_imm(input bit [15:0] imm, input bit [1:0] mode);
    case (mode)
      2'd1:    return {16'h0000, imm};
      2'd2:    return {imm, 16'h0000};
      default: return 32'(int'(shortint'(imm)));
    endcase
  endfunction

  function automatic stim_t mk(input bit v, input bit [31:0] ir);
    stim_t s;
    s = '0;
    s.v = v;
    s.ir = ir;
    return s;
  endfunction

  // One clock of stimulus: drive, record what the DUT must show during this
  // cycle, then advance the reference model across the coming edge.
  task automatic cyc(input stim_t s);
    rec_t r;
    bit [4:0] rs, rt;
    bit hz;
    @(posedge sys_clk);
    #1;
    bus.di_Valid = s.v;  bus.di_IR = s.ir;
    di_WE = s.we;  di_WA = s.wa;  di_WD = s.wd;
    ci_ImmMode = s.mode;  ci_Ctrl = s.ctrl;
    i_EX_MemRead = s.mr;  i_EX_RT = s.exrt;
    i_Stall = s.st;  i_Flush = s.fl;
    rs = s.ir[25:21];
    rt = s.ir[20:16];
    hz = s.v && s.mr && (s.exrt != 0) && (s.exrt == rs || s.exrt == rt);
    r.op = s.ir[31:26];
    r.fn = s.ir[5:0];
    r.st = m_st;
    if (s.fl) begin
      r.ready = 1'b1;
      m_st.valid = 1'b0;
    end else if (s.st) begin
      r.ready = 1'b0;
    end else if (hz) begin
      r.ready = 1'b0;
      m_st.valid = 1'b0;
    end else begin
      r.ready    = 1'b1;
      m_st.valid = s.v;
      m_st.rsval = rf_read(rs, s);
      m_st.rtval = rf_read(rt, s);
      m_st.imm   = ext_imm(s.ir[15:0], s.mode);
      m_st.rs    = rs;
      m_st.rt    = rt;
      m_st.rd    = s.ir[15:11];
      m_st.ctrl  = s.ctrl;
    end
    if (s.we && s.wa != 0) m_rf[s.wa] = s.wd;
    sb.push_back(r);
  endtask

  // Monitor: every pending record is compared against what the DUT shows.
  always @(negedge sys_clk) begin
    if (sys_rst_n && sb.size() > 0) begin
      mon_r = sb.pop_front();
      chk("ready",  32'(bus.do_Ready), 32'(mon_r.ready));
      chk("opcode", 32'(o_Opcode),     32'(mon_r.op));
      chk("funct",  32'(o_Function),   32'(mon_r.fn));
      chk("valid",  32'(bus.do_Valid), 32'(mon_r.st.valid));
      if (mon_r.st.valid) begin
        chk("rsval", bus.do_RSVal,     mon_r.st.rsval);
        chk("rtval", bus.do_RTVal,     mon_r.st.rtval);
        chk("imm",   bus.do_Imm,       mon_r.st.imm);
        chk("rs",    32'(bus.do_RS),   32'(mon_r.st.rs));
        chk("rt",    32'(bus.do_RT),   32'(mon_r.st.rt));
        chk("rd",    32'(bus.do_RD),   32'(mon_r.st.rd));
        chk("ctrl",  32'(bus.co_Ctrl), 32'(mon_r.st.ctrl));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge sys_clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.do_Valid), 32'd0);
    chk({tag, "_rsval"}, bus.do_RSVal, 32'd0);
    chk({tag, "_rtval"}, bus.do_RTVal, 32'd0);
    chk({tag, "_imm"},   bus.do_Imm,   32'd0);
    chk({tag, "_rs"},    32'(bus.do_RS), 32'd0);
    chk({tag, "_rt"},    32'(bus.do_RT), 32'd0);
    chk({tag, "_rd"},    32'(bus.do_RD), 32'd0);
    chk({tag, "_ctrl"},  32'(bus.co_Ctrl), 32'd0);
  endtask

  task automatic model_clear();
    m_st = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic do_reset();
    cyc(mk(1'b0, 32'd0));
    drain();
    @(posedge sys_clk);
    #1;
    bus.di_Valid = 1'b1;
    bus.di_IR = $urandom;
    sys_rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    model_clear();
    @(negedge sys_clk);
    bus.di_Valid = 1'b0;
    bus.di_IR = 32'd0;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    stim_t s;
    bus.di_Valid = 1'b0;  bus.di_IR = 32'd0;
    di_WE = 1'b0;  di_WA = 5'd0;  di_WD = 32'd0;
    ci_ImmMode = 2'd0;  ci_Ctrl = 10'd0;
    i_EX_MemRead = 1'b0;  i_EX_RT = 5'd0;
    i_Stall = 1'b0;  i_Flush = 1'b0;
    model_clear();
    #1 sys_rst_n = 1'b0;
    #2 chk_zero("rst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Normal decode: r5 = 0x12345678 then add r7,r5,r6.
    s = mk(1'b0, 32'd0); s.we = 1'b1; s.wa = 5'd5; s.wd = 32'h1234_5678;
    cyc(s);
    s = mk(1'b1, 32'h00A6_3820); s.ctrl = 10'h2A5;
    cyc(s);
    cyc(mk(1'b0, 32'd0));
    chk("add_valid", 32'(bus.do_Valid), 32'd1);
    chk("add_rs",    32'(bus.do_RS),    32'd5);
    chk("add_rsval", bus.do_RSVal,      32'h1234_5678);
    chk("add_rd",    32'(bus.do_RD),    32'd7);

    // Immediate modes on imm 0x8001.
    s = mk(1'b1, {6'h08, 5'd1, 5'd2, 16'h8001}); s.mode = 2'd0;
    cyc(s);
    s.mode = 2'd1; cyc(s);
    chk("imm_sign", bus.do_Imm, 32'hFFFF_8001);
    s.mode = 2'd2; cyc(s);
    chk("imm_zero", bus.do_Imm, 32'h0000_8001);
    s.mode = 2'd3; cyc(s);
    chk("imm_upper", bus.do_Imm, 32'h8001_0000);
    cyc(mk(1'b0, 32'd0));
    chk("imm_mode3", bus.do_Imm, 32'hFFFF_8001);

    // Bypass on rs=3, then r0 write is dropped.
    s = mk(1'b1, {6'h00, 5'd3, 5'd0, 5'd1, 11'h020});
    s.we = 1'b1; s.wa = 5'd3; s.wd = 32'hDEAD_BEEF;
    cyc(s);
    s = mk(1'b0, 32'd0); s.we = 1'b1; s.wa = 5'd0; s.wd = 32'hFFFF_FFFF;
    cyc(s);
    chk("bypass_rsval", bus.do_RSVal, 32'hDEAD_BEEF);
    cyc(mk(1'b1, {6'h00, 5'd0, 5'd0, 5'd2, 11'h020}));
    cyc(mk(1'b0, 32'd0));
    chk("r0_rsval", bus.do_RSVal, 32'd0);
    chk("r0_rtval", bus.do_RTVal, 32'd0);

    // Load-use on rt=4: one bubble, then the held IR goes through.
    s = mk(1'b1, {6'h00, 5'd3, 5'd4, 5'd9, 11'h020}); s.mr = 1'b1; s.exrt = 5'd4;
    cyc(s);
    #1 chk("lu_ready", 32'(bus.do_Ready), 32'd0);
    s.mr = 1'b0;
    cyc(s);
    chk("lu_bubble", 32'(bus.do_Valid), 32'd0);
    s = mk(1'b1, {6'h00, 5'd3, 5'd0, 5'd9, 11'h020}); s.mr = 1'b1; s.exrt = 5'd0;
    cyc(s);
    chk("lu_after", 32'(bus.do_Valid), 32'd1);
    #1 chk("lu_rt0_ready", 32'(bus.do_Ready), 32'd1);

    // Stall for 3 cycles holds the entry; stall+flush squashes it.
    s = mk(1'b1, {6'h00, 5'd5, 5'd3, 5'd11, 11'h020}); s.ctrl = 10'h155;
    cyc(s);
    for (int i = 0; i < 3; i++) begin
      s = mk(1'b1, $urandom); s.st = 1'b1; s.ctrl = 10'h0AA;
      cyc(s);
    end
    cyc(mk(1'b0, 32'd0));
    chk("stall_ctrl",  32'(bus.co_Ctrl), 32'h155);
    chk("stall_rsval", bus.do_RSVal,     32'h1234_5678);
    s = mk(1'b1, {6'h00, 5'd5, 5'd3, 5'd11, 11'h020}); s.st = 1'b1; s.fl = 1'b1;
    cyc(s);
    #1 chk("flush_ready", 32'(bus.do_Ready), 32'd1);
    cyc(mk(1'b0, 32'd0));
    chk("flush_valid", 32'(bus.do_Valid), 32'd0);

    // Mid-run reset with di_Valid high, then r5 must read back as 0.
    do_reset();
    cyc(mk(1'b1, {6'h00, 5'd5, 5'd5, 5'd1, 11'h020}));
    cyc(mk(1'b0, 32'd0));
    chk("postrst_valid", 32'(bus.do_Valid), 32'd1);
    chk("postrst_rsval", bus.do_RSVal, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s.v    = ($urandom_range(0, 9) < 8);
      s.ir   = $urandom;
      s.we   = 1'($urandom_range(0, 1));
      s.wa   = 5'($urandom);
      s.wd   = $urandom;
      s.mode = 2'($urandom);
      s.mr   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       s.exrt = s.ir[25:21];
        1:       s.exrt = s.ir[20:16];
        default: s.exrt = 5'($urandom);
      endcase
      s.st   = ($urandom_range(0, 6) == 0);
      s.fl   = ($urandom_range(0, 9) == 0);
      s.ctrl = 10'($urandom);
      cyc(s);
    end
    cyc(mk(1'b0, 32'd0));
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
